// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default bit timing.
// Meant to be reused by a future uart_tx.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 32'd520;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous bit.
// Both flops reset to RESET_VAL so that an idle line does not look like an edge.
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Synchronizer chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-byte valid/ready output holding register.
// Bad stop bits pulse frame_err and park the receiver until the line returns high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [15:0] HALF_TICK = 16'(CLKS_PER_BIT / 32'd2);
  localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 32'd1);

  logic        rxd_s;
  logic        frame_done_s;
  logic        handshake_s;

  uart_state_e state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;

  bit_sync #(
    .RESET_VAL (1'b1)
  ) u_rxd_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rxd),
    .q     (rxd_s)
  );

  // Next-state, bit timing and output holding-register logic.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    valid_d      = valid_q;
    overrun_d    = overrun_q;
    frame_err_d  = 1'b0;
    frame_done_s = 1'b0;
    handshake_s  = valid_q & ready;

    case (state_q)
      IDLE: begin
        timer_d = 16'd0;
        if (!rxd_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (timer_q == HALF_TICK) begin
          timer_d   = 16'd0;
          bit_idx_d = 3'd0;
          if (!rxd_s) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      DATA: begin
        if (timer_q == LAST_TICK) begin
          timer_d            = 16'd0;
          shift_d[bit_idx_q] = rxd_s;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      STOP: begin
        if (timer_q == LAST_TICK) begin
          timer_d = 16'd0;
          if (rxd_s) begin
            frame_done_s = 1'b1;
            state_d      = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      BREAK: begin
        timer_d = 16'd0;
        if (rxd_s) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end
      default: begin
        timer_d   = 16'd0;
        bit_idx_d = 3'd0;
        state_d   = IDLE;
      end
    endcase

    // A finished byte wins over the consumer's clear when both land in one cycle.
    if (frame_done_s && (!valid_q || ready)) begin
      data_d    = shift_q;
      valid_d   = 1'b1;
      overrun_d = handshake_s ? 1'b0 : overrun_q;
    end else if (frame_done_s) begin
      overrun_d = 1'b1;
    end else if (handshake_s) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      timer_q     <= 16'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: the bench is the serial transmitter and keeps a
// frame-level model (when each frame must complete, what it carries) checked every cycle.
module tb_uart_rx;

  localparam int CPB = 16;
  // Line fall to stop-sample edge: 2 sync flops + 1 detect edge + half bit + 1 + 9 bit times.
  localparam int DONE_LAT = 3 + (CPB / 2) + 1 + 9 * CPB;

  typedef struct {
    int         at_cyc;
    logic [7:0] b;
    bit         good;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxd = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  int         cyc = 0;
  logic       ready_seen = 1'b0;
  int         n_pass = 0;
  int         n_total = 0;

  ev_t        evq[$];
  logic [7:0] rise_q[$];
  int         rise_cyc = 0;
  int         ferr_cnt = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    ready_seen <= ready;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Sends one 8N1 frame; a bad frame holds the stop level low for stop_len cycles.
  task automatic send(input logic [7:0] b, input bit good, input int stop_len, output int k);
    k = cyc;
    evq.push_back('{k + DONE_LAT, b, good});
    rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(CPB);
    end
    rxd = good;
    idle(good ? CPB : stop_len);
    if (!good) begin
      rxd = 1'b1;
      idle(CPB);
    end
  endtask

  task automatic glitch(input int len);
    rxd = 1'b0;
    idle(len);
    rxd = 1'b1;
    idle(2 * CPB);
  endtask

  // Frame-level reference model plus per-cycle comparison of all outputs.
  always @(negedge clk) begin
    ev_t ev;
    bit  cg;
    bit  cb;
    bit  hs;
    if (!reset) begin
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
      evq.delete();
    end else begin
      cg = 1'b0;
      cb = 1'b0;
      if (evq.size() > 0 && evq[0].at_cyc == cyc) begin
        ev = evq.pop_front();
        cg = ev.good;
        cb = !ev.good;
      end
      hs = m_valid && ready_seen;
      if (cg && (!m_valid || ready_seen)) begin
        m_data  = ev.b;
        m_valid = 1'b1;
        if (hs) m_ovr = 1'b0;
      end else if (cg) begin
        m_ovr = 1'b1;
      end else if (hs) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
      m_ferr = cb;
    end
    chk("data", 32'(data), 32'(m_data));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("frame_err", 32'(frame_err), 32'(m_ferr));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    if (valid && !prev_valid) begin
      rise_q.push_back(data);
      rise_cyc = cyc;
    end
    if (frame_err) ferr_cnt++;
    prev_valid = valid;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1);
  end

  initial begin
    int  k;
    int  r0;
    int  f0;
    bit  done;
    idle(4);
    chk("reset_data", 32'(data), 32'h00);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_overrun", 32'(overrun), 32'h0);
    reset = 1'b1;
    idle(2 * CPB);

    // Plain byte with a consumer that is always ready.
    ready = 1'b1;
    r0 = rise_q.size();
    f0 = ferr_cnt;
    send(8'hA5, 1'b1, 0, k);
    idle(20);
    chk("a5_rises", 32'(rise_q.size() - r0), 32'd1);
    chk("a5_data", 32'(rise_q[rise_q.size() - 1]), 32'hA5);
    chk("a5_latency", 32'(rise_cyc - k), 32'd156);
    chk("a5_no_ferr", 32'(ferr_cnt - f0), 32'd0);

    // Short low glitch must abort in START.
    r0 = rise_q.size();
    glitch(3);
    idle(2 * CPB);
    chk("glitch_rises", 32'(rise_q.size() - r0), 32'd0);
    chk("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);

    // Bad stop bit held low, then a good frame.
    send(8'h3C, 1'b0, 40, k);
    idle(CPB);
    chk("break_ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
    chk("break_rises", 32'(rise_q.size() - r0), 32'd0);
    chk("break_valid", 32'(valid), 32'h0);
    send(8'h5A, 1'b1, 0, k);
    idle(20);
    chk("after_break_data", 32'(rise_q[rise_q.size() - 1]), 32'h5A);

    // Back-to-back with a stalled consumer: second byte is dropped.
    ready = 1'b0;
    send(8'h11, 1'b1, 0, k);
    send(8'h22, 1'b1, 0, k);
    idle(20);
    chk("ovr_data", 32'(data), 32'h11);
    chk("ovr_valid", 32'(valid), 32'h1);
    chk("ovr_flag", 32'(overrun), 32'h1);
    ready = 1'b1;
    idle(1);
    ready = 1'b0;
    idle(2);
    chk("ovr_clr_valid", 32'(valid), 32'h0);
    chk("ovr_clr_flag", 32'(overrun), 32'h0);

    // Reset in the middle of data bit 4 of 0xFF.
    r0 = rise_q.size();
    rxd = 1'b0;
    idle(CPB);
    rxd = 1'b1;
    idle(4 * CPB + CPB / 2);
    reset = 1'b0;
    idle(1);
    chk("midrst_data", 32'(data), 32'h00);
    chk("midrst_valid", 32'(valid), 32'h0);
    chk("midrst_ferr", 32'(frame_err), 32'h0);
    chk("midrst_ovr", 32'(overrun), 32'h0);
    idle(4);
    reset = 1'b1;
    idle(2 * CPB);
    send(8'h81, 1'b1, 0, k);
    idle(20);
    chk("midrst_rises", 32'(rise_q.size() - r0), 32'd1);
    chk("midrst_81", 32'(data), 32'h81);

    // Three back-to-back frames with ready held high.
    ready = 1'b1;
    idle(2);
    r0 = rise_q.size();
    send(8'h00, 1'b1, 0, k);
    send(8'hFF, 1'b1, 0, k);
    send(8'h55, 1'b1, 0, k);
    idle(20);
    chk("b2b_rises", 32'(rise_q.size() - r0), 32'd3);
    chk("b2b_0", 32'(rise_q[r0]), 32'h00);
    chk("b2b_1", 32'(rise_q[r0 + 1]), 32'hFF);
    chk("b2b_2", 32'(rise_q[r0 + 2]), 32'h55);
    chk("b2b_no_ferr", 32'(ferr_cnt - f0), 32'd1);

    // Random frames, glitches and bad stops against a randomly stalling consumer.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          int sel;
          sel = $urandom_range(0, 99);
          if (sel < 70) begin
            send(8'($urandom_range(0, 255)), 1'b1, 0, k);
            idle($urandom_range(0, 8));
          end else if (sel < 85) begin
            glitch($urandom_range(1, 6));
          end else begin
            send(8'($urandom_range(0, 255)), 1'b0, $urandom_range(CPB, 3 * CPB), k);
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          ready = 1'($urandom_range(0, 1));
          idle(1);
        end
      end
    join
    ready = 1'b1;
    idle(200);
    chk("events_drained", 32'(evq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
